// File: rtl/data_memory_bytelane.sv
// data_memory_bytelane
//   Byte-addressed, little-endian data memory for the single-cycle core.
//   Stores of byte/half/word go through per-lane write enables; loads are
//   combinational and sign- or zero-extended. A clear engine launched by
//   reset zeroes every word, one per cycle, while busy stalls the core.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   addr         byte address; word index = addr[DEPTH_LOG2+1:2]
//   WD           store data, right-aligned
//   memWrite     store request
//   memRead      load request
//   size         00 byte, 01 half, 10 word, 11 illegal
//   unsignedLoad 1 = zero-extend sub-word loads, 0 = sign-extend
//   RD           extended load data (0 when not a valid load)
//   misaligned   combinational alignment fault
//   busy         clear sequence in progress
//
// State | meaning
// IDLE  | normal operation, core accesses allowed
// CLEAR | zeroing word clr_idx each cycle, core accesses blocked

module data_memory_bytelane #(
  parameter int DEPTH_LOG2     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] WD,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  output logic [31:0] RD,
  output logic        misaligned,
  output logic        busy
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_idx_q, clr_idx_d;

  logic [31:0]           mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  req;

  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;

  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;

  // Address bits above the array wrap and are intentionally ignored.
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];

  assign word_idx = addr[DEPTH_LOG2+1:2];
  assign req      = memRead | memWrite;

  always_comb begin
    misaligned = 1'b0;
    if (req) begin
      unique case (size)
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = addr[0];
        2'b10:   misaligned = (addr[1:0] != 2'b00);
        default: misaligned = 1'b1;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // FSM: next state. The counter wraps naturally to 0 on the last word.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      S_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == S_CLEAR);
  end

  // Write port: clear engine has priority; nothing is written under reset.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = word_idx;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    if (!reset) begin
      if (busy) begin
        mem_we    = 1'b1;
        mem_idx   = clr_idx_q;
        mem_be    = 4'b1111;
        mem_wdata = 32'h0;
      end else if (memWrite && !misaligned) begin
        mem_we = 1'b1;
        unique case (size)
          2'b00: begin
            mem_be    = 4'b0001 << addr[1:0];
            mem_wdata = {4{WD[7:0]}};
          end
          2'b01: begin
            mem_be    = addr[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{WD[15:0]}};
          end
          default: begin
            mem_be    = 4'b1111;
            mem_wdata = WD;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Read port: reads the array before this cycle's write lands.
  always_comb begin
    rd_word = mem_q[word_idx];
    unique case (addr[1:0])
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

    RD = 32'h0;
    if (memRead && !misaligned && !busy) begin
      unique case (size)
        2'b00:   RD = {{24{rd_byte[7] & ~unsignedLoad}}, rd_byte};
        2'b01:   RD = {{16{rd_half[15] & ~unsignedLoad}}, rd_half};
        2'b10:   RD = rd_word;
        default: RD = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_bytelane.sv
module tb_data_memory_bytelane;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] WD;
  logic        memWrite;
  logic        memRead;
  logic [1:0]  size;
  logic        unsignedLoad;
  logic [31:0] RD;
  logic        misaligned;
  logic        busy;

  int checks = 0;
  int errors = 0;

  data_memory_bytelane #(.DEPTH_LOG2(DL), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .WD(WD), .memWrite(memWrite),
    .memRead(memRead), .size(size), .unsignedLoad(unsignedLoad),
    .RD(RD), .misaligned(misaligned), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic we, logic re, logic [1:0] sz, logic uns,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] er, logic em);
    vec_t v;
    v.name = n; v.we = we; v.re = re; v.sz = sz; v.uns = uns;
    v.a = a; v.wd = wd; v.exp_rd = er; v.exp_mis = em;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", n, act, exp);
    end
  endtask

  task automatic idle_inputs();
    memWrite = 0; memRead = 0; size = 2'b10; unsignedLoad = 0; addr = 0; WD = 0;
  endtask

  // Counts consecutive samples with busy high, starting from the current one.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      if (busy !== 1'b1) break;
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    idle_inputs();

    // Reset and initial clear
    step(); step();
    check32("busy_in_reset", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    count_busy(n);
    check32("clear_busy_cycles", n, DEPTH);
    check32("busy_after_clear", {31'b0, busy}, 32'd0);

    memRead = 1;
    for (int i = 0; i < DEPTH; i++) begin
      addr = 32'(i * 4);
      #3;
      check32($sformatf("cleared_word_%0d", i), RD, 32'h0);
      step();
    end
    idle_inputs();

    //              name          we re sz    uns addr    wd            exp_rd        mis
    vecs.push_back(mk("sw_10",    1, 0, 2'b10, 0, 32'h10, 32'h11223344, 32'h0,        0));
    vecs.push_back(mk("sb_12",    1, 0, 2'b00, 0, 32'h12, 32'h000000AB, 32'h0,        0));
    vecs.push_back(mk("lw_10",    0, 1, 2'b10, 0, 32'h10, 32'h0,        32'h11AB3344, 0));
    vecs.push_back(mk("lb_12",    0, 1, 2'b00, 0, 32'h12, 32'h0,        32'hFFFFFFAB, 0));
    vecs.push_back(mk("lbu_12",   0, 1, 2'b00, 1, 32'h12, 32'h0,        32'h000000AB, 0));
    vecs.push_back(mk("lb_13",    0, 1, 2'b00, 0, 32'h13, 32'h0,        32'h00000011, 0));
    vecs.push_back(mk("lb_10",    0, 1, 2'b00, 0, 32'h10, 32'h0,        32'h00000044, 0));
    vecs.push_back(mk("sh_22",    1, 0, 2'b01, 0, 32'h22, 32'h00008001, 32'h0,        0));
    vecs.push_back(mk("lh_22",    0, 1, 2'b01, 0, 32'h22, 32'h0,        32'hFFFF8001, 0));
    vecs.push_back(mk("lhu_22",   0, 1, 2'b01, 1, 32'h22, 32'h0,        32'h00008001, 0));
    vecs.push_back(mk("lw_20",    0, 1, 2'b10, 0, 32'h20, 32'h0,        32'h80010000, 0));
    vecs.push_back(mk("sw_21_mis",1, 1, 2'b10, 0, 32'h21, 32'hFFFFFFFF, 32'h0,        1));
    vecs.push_back(mk("sh_23_mis",1, 1, 2'b01, 0, 32'h23, 32'hFFFFFFFF, 32'h0,        1));
    vecs.push_back(mk("sh_21_mis",1, 0, 2'b01, 0, 32'h21, 32'hFFFFFFFF, 32'h0,        1));
    vecs.push_back(mk("sz11_mis", 1, 1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, 32'h0,        1));
    vecs.push_back(mk("sz11_noreq",0,0, 2'b11, 0, 32'h21, 32'h0,        32'h0,        0));
    vecs.push_back(mk("lw_20_kept",0,1, 2'b10, 0, 32'h20, 32'h0,        32'h80010000, 0));
    vecs.push_back(mk("lw_24_kept",0,1, 2'b10, 0, 32'h24, 32'h0,        32'h00000000, 0));
    vecs.push_back(mk("sh_20",    1, 0, 2'b01, 0, 32'h20, 32'h12347FFF, 32'h0,        0));
    vecs.push_back(mk("lw_20_b",  0, 1, 2'b10, 0, 32'h20, 32'h0,        32'h80017FFF, 0));
    vecs.push_back(mk("lh_20",    0, 1, 2'b01, 0, 32'h20, 32'h0,        32'h00007FFF, 0));
    vecs.push_back(mk("no_read",  0, 0, 2'b10, 0, 32'h10, 32'h0,        32'h0,        0));
    vecs.push_back(mk("sw_04",    1, 0, 2'b10, 0, 32'h04, 32'hDEADBEEF, 32'h0,        0));
    vecs.push_back(mk("rw_same",  1, 1, 2'b10, 0, 32'h04, 32'h12345678, 32'hDEADBEEF, 0));
    vecs.push_back(mk("rw_next",  0, 1, 2'b10, 0, 32'h04, 32'h0,        32'h12345678, 0));
    vecs.push_back(mk("sw_alias", 1, 0, 2'b10, 0, 32'h40, 32'hA5A50F0F, 32'h0,        0));
    vecs.push_back(mk("lw_00",    0, 1, 2'b10, 0, 32'h00, 32'h0,        32'hA5A50F0F, 0));
    vecs.push_back(mk("lhu_42",   0, 1, 2'b01, 1, 32'h42, 32'h0,        32'h0000A5A5, 0));

    foreach (vecs[k]) begin
      memWrite = vecs[k].we; memRead = vecs[k].re; size = vecs[k].sz;
      unsignedLoad = vecs[k].uns; addr = vecs[k].a; WD = vecs[k].wd;
      #3;
      check32({vecs[k].name, "_rd"}, RD, vecs[k].exp_rd);
      check32({vecs[k].name, "_mis"}, {31'b0, misaligned}, {31'b0, vecs[k].exp_mis});
      step();
    end
    idle_inputs();

    // Reset mid-clear at clr_idx=7 restarts the full sweep.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check32("busy_mid_clear", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      if (busy !== 1'b1) break;
      n++;
      if (i == 12) begin
        // Word 0 is already cleared by now; a leaked store would persist.
        memWrite = 1; memRead = 1; size = 2'b10; addr = 32'h0; WD = 32'h00000055;
        #3;
        check32("rd_while_busy", RD, 32'h0);
      end
      step();
      idle_inputs();
    end
    check32("restart_busy_cycles", n, DEPTH);

    memRead = 1; size = 2'b10;
    addr = 32'h00; #3; check32("busy_store_dropped", RD, 32'h0); step();
    addr = 32'h04; #3; check32("word1_recleared", RD, 32'h0); step();
    addr = 32'h20; #3; check32("word8_recleared", RD, 32'h0); step();
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
